instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
- Registered, handshaked instruction-decode pipeline stage for the 16-bit CR16-style datapath.
- Sits between instruction fetch and the register-file/ALU stage. Splits each instruction into opcode, register addresses and an extended immediate, classifies the instruction type, and flags illegal encodings.
- Valid/ready on both sides, with a 2-entry skid buffer so that in_ready is a registered signal.

Parameters:
- DATA_W, 16: immediate output width (>=16); immediates extended to this width.
- REG_AW, 4: register address width; taken from the low REG_AW bits of each 4-bit field (REG_AW<=4).
- LUI_SHIFT, 8: left shift applied to the 8-bit immediate for LUI.

Ports:
- clk, in, 1: clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- flush, in, 1: synchronous pipeline flush (branch taken).
- in_valid, in, 1: fetch presents an instruction.
- in_ready, out, 1: stage can accept; registered.
- in_instr, in, 16: instruction word.
- out_valid, out, 1: decoded bundle valid.
- out_ready, in, 1: downstream accepts.
- out_opcode, out, 8: {instr[15:12], instr[7:4]}.
- out_rdest, out, REG_AW: instr[11:8].
- out_rsrc, out, REG_AW: instr[3:0].
- out_imm, out, DATA_W: extended immediate.
- out_is_imm, out, 1: instruction uses immediate instead of Rsrc.
- out_illegal, out, 1: undefined encoding.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0, except in_ready=1 once reset is released.
  - Both skid entries are empty.
- Decoding is purely a function of the accepted word. It is captured into a skid entry on the accept edge (in_valid & in_ready).
- Latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N, if the output slot is empty or draining.
- Classes, by op = instr[15:12]:
  - 0000 R-type: is_imm=0. Legal ext values are instr[7:4] in {0001, 0010, 0011, 0101, 1001, 1011, 1101}; any other ext sets illegal=1.
  - 0101/1001/1011/1101 (ADDI/SUBI/CMPI/MOVI): is_imm=1; imm = instr[7:0] sign-extended to DATA_W.
  - 0001/0010/0011 (ANDI/ORI/XORI): is_imm=1; imm = instr[7:0] zero-extended.
  - 1111 LUI: is_imm=1; imm = zero-extend(instr[7:0]) << LUI_SHIFT, truncated to DATA_W.
  - 0100 (load/store/jump class) and 1000 (shift class): is_imm=0 and imm=0, except op 1000 with instr[7:5]=000 (LSHI): is_imm=1, imm = instr[4:0] sign-extended.
  - 0110, 0111, 1010, 1100, 1110: illegal=1, is_imm=0, imm=0.
  - Illegal words still propagate, with out_illegal=1; the trap decision is made downstream.
- Handshake:
  - A transfer occurs on each edge where valid & ready are both high.
  - While out_valid=1 and out_ready=0, every out_* field stays stable.
  - in_ready=0 only when both skid entries are occupied.
  - in_ready deasserts in the cycle after the second entry fills, and reasserts the cycle after a drain frees an entry.
- Ordering is strict FIFO; instructions are never reordered or duplicated.
- Simultaneous accept and drain when the stage holds one entry: occupancy stays 1, and the new instruction becomes the output next cycle.
- Flush:
  - At the edge where flush=1, both entries are invalidated and any input presented that cycle is discarded.
  - out_valid=0 next cycle and in_ready=1.
  - Flush overrides concurrent in_valid and out_ready; an output transfer that same edge still counts as delivered downstream.
- Reset asserted mid-operation immediately clears all state, regardless of the clock.

Optional Feature:
- DECODE_PERF_CNT_EN defined:
  - Adds outputs perf_decoded (32) and perf_illegal (16).
  - perf_decoded increments on each output transfer (out_valid & out_ready).
  - perf_illegal increments on each output transfer with out_illegal=1.
  - Both counters saturate at all-ones, are cleared by reset, and are not cleared by flush.
- Not defined: these ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- ADDI with in_instr=0x5_3_FF (0x53FF), out_ready=1, DATA_W=16 → next cycle: opcode=0x5F, rdest=3, is_imm=1, imm=0xFFFF, illegal=0.
- ANDI 0x1280 → imm=0x0080; LUI 0xF1AB → imm=0xAB00, rdest=1; R-type ADD 0x0152 → opcode=0x05, rdest=1, rsrc=2, is_imm=0.
- Illegal words: 0x6000 → illegal=1; 0x00F0 (R-type, ext=1111) → illegal=1. With DECODE_PERF_CNT_EN, perf_illegal=2 after both transfer.
- Backpressure: stream 0x5101, 0x5202, 0x5303 with out_ready=0. The first two are accepted, then in_ready=0 and the output holds 0x5101's decode stably. Raising out_ready delivers all three in order, with no loss or duplicates.
- Flush with 2 entries held and in_valid=1 on the same edge → next cycle out_valid=0 and in_ready=1; nothing from those three words appears later.
- Drop reset_n asynchronously mid-stream (between edges) → outputs immediately 0 and counters 0; after release, in_ready=1 and the first new instruction decodes correctly.

Source files
------------

// File: rtl/instr_decode_stage.sv
// ============================================================================
// Module      : instr_decode_stage
// Description : Registered valid/ready decode stage for a 16-bit CR16-style
//               datapath; 2-entry skid buffer, registered in_ready.
//               Optional DECODE_PERF_CNT_EN adds saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decode_stage #(
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 4,
  parameter int LUI_SHIFT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_opcode,
  output logic [REG_AW-1:0] out_rdest,
  output logic [REG_AW-1:0] out_rsrc,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_is_imm,
  output logic              out_illegal
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_decoded,
  output logic [15:0]       perf_illegal
`endif
);

  typedef struct packed {
    logic [7:0]        opcode;
    logic [REG_AW-1:0] rdest;
    logic [REG_AW-1:0] rsrc;
    logic [DATA_W-1:0] imm;
    logic              is_imm;
    logic              illegal;
  } entry_t;

  entry_t            dec;
  entry_t            ent0_q, ent0_d;
  entry_t            ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              push, pop;

  logic [DATA_W-1:0] sext8, zext8, lui_imm, sext5;

  assign sext8   = {{(DATA_W-8){in_instr[7]}}, in_instr[7:0]};
  assign zext8   = {{(DATA_W-8){1'b0}}, in_instr[7:0]};
  assign lui_imm = zext8 << LUI_SHIFT;
  assign sext5   = {{(DATA_W-5){in_instr[4]}}, in_instr[4:0]};

  always_comb begin
    dec        = '0;
    dec.opcode = {in_instr[15:12], in_instr[7:4]};
    dec.rdest  = in_instr[8 +: REG_AW];
    dec.rsrc   = in_instr[0 +: REG_AW];
    case (in_instr[15:12])
      4'b0000: begin
        case (in_instr[7:4])
          4'b0001, 4'b0010, 4'b0011, 4'b0101,
          4'b1001, 4'b1011, 4'b1101: dec.illegal = 1'b0;
          default:                   dec.illegal = 1'b1;
        endcase
      end
      4'b0101, 4'b1001, 4'b1011, 4'b1101: begin
        dec.is_imm = 1'b1;
        dec.imm    = sext8;
      end
      4'b0001, 4'b0010, 4'b0011: begin
        dec.is_imm = 1'b1;
        dec.imm    = zext8;
      end
      4'b1111: begin
        dec.is_imm = 1'b1;
        dec.imm    = lui_imm;
      end
      4'b1000: begin
        // LSHI is the only shift form carrying an immediate
        if (in_instr[7:5] == 3'b000) begin
          dec.is_imm = 1'b1;
          dec.imm    = sext5;
        end
      end
      4'b0100: dec.illegal = 1'b0;
      default: dec.illegal = 1'b1;
    endcase
  end

  assign push = in_valid & rdy_q;
  assign pop  = (cnt_q != 2'd0) & out_ready;

  // Entry 0 is always the head; entry 1 only ever holds the second-oldest word
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush) begin
      ent0_d = '0;
      cnt_d  = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = dec;
          else               ent1_d = dec;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_d = dec;
          end else begin
            ent0_d = ent1_q;
            ent1_d = dec;
          end
        end
        default: ;
      endcase
    end
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = (cnt_q != 2'd0);
  assign out_opcode  = ent0_q.opcode;
  assign out_rdest   = ent0_q.rdest;
  assign out_rsrc    = ent0_q.rsrc;
  assign out_imm     = ent0_q.imm;
  assign out_is_imm  = ent0_q.is_imm;
  assign out_illegal = ent0_q.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] pdec_q;
  logic [15:0] pill_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pdec_q <= '0;
      pill_q <= '0;
    end else if (pop) begin
      if (pdec_q != '1) pdec_q <= pdec_q + 32'd1;
      if (ent0_q.illegal && (pill_q != '1)) pill_q <= pill_q + 16'd1;
    end
  end

  assign perf_decoded = pdec_q;
  assign perf_illegal = pill_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
// ============================================================================
// Module      : tb_instr_decode_stage
// Description : Directed scoreboard bench for instr_decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [3:0]  out_rdest;
  logic [3:0]  out_rsrc;
  logic [15:0] out_imm;
  logic        out_is_imm;
  logic        out_illegal;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_decoded;
  logic [15:0] perf_illegal;
`endif

  instr_decode_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_rdest  (out_rdest),
    .out_rsrc   (out_rsrc),
    .out_imm    (out_imm),
    .out_is_imm (out_is_imm),
    .out_illegal(out_illegal)
`ifdef DECODE_PERF_CNT_EN
    ,
    .perf_decoded(perf_decoded),
    .perf_illegal(perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  opc;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        isi;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_dec = 0;
  int   exp_ill = 0;
  bit   chk_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] o, input logic [3:0] rd, input logic [3:0] rs,
                              input logic [15:0] imm, input logic isi, input logic ill);
    exp_t e;
    e.opc = o; e.rd = rd; e.rs = rs; e.imm = imm; e.isi = isi; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t model(input logic [15:0] w);
    exp_t       e;
    logic [3:0] op;
    op    = w[15:12];
    e.opc = {op, w[7:4]};
    e.rd  = w[11:8];
    e.rs  = w[3:0];
    e.imm = 16'h0000;
    e.isi = 1'b0;
    e.ill = 1'b0;
    if (op == 4'h0) begin
      e.ill = !(w[7:4] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD});
    end else if (op inside {4'h5, 4'h9, 4'hB, 4'hD}) begin
      e.isi = 1'b1; e.imm = {{8{w[7]}}, w[7:0]};
    end else if (op inside {4'h1, 4'h2, 4'h3}) begin
      e.isi = 1'b1; e.imm = {8'h00, w[7:0]};
    end else if (op == 4'hF) begin
      e.isi = 1'b1; e.imm = {w[7:0], 8'h00};
    end else if (op == 4'h8 && w[7:5] == 3'b000) begin
      e.isi = 1'b1; e.imm = {{11{w[4]}}, w[4:0]};
    end else if (op inside {4'h6, 4'h7, 4'hA, 4'hC, 4'hE}) begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Called at a falling edge; drives inputs for the next rising edge.
  task automatic step(input logic v, input logic [15:0] ins, input exp_t e,
                      input logic ordy, input logic fl);
    exp_t h;
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (chk_rdy) chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
`ifdef DECODE_PERF_CNT_EN
    chk("perf_decoded", perf_decoded, 32'(exp_dec));
    chk("perf_illegal", 32'(perf_illegal), 32'(exp_ill));
`endif
    if (out_valid && sb.size() != 0) begin
      chk("opcode",  32'(out_opcode),  32'(sb[0].opc));
      chk("rdest",   32'(out_rdest),   32'(sb[0].rd));
      chk("rsrc",    32'(out_rsrc),    32'(sb[0].rs));
      chk("imm",     32'(out_imm),     32'(sb[0].imm));
      chk("is_imm",  32'(out_is_imm),  32'(sb[0].isi));
      chk("illegal", 32'(out_illegal), 32'(sb[0].ill));
      if (ordy) begin
        h = sb.pop_front();
        exp_dec++;
        if (h.ill) exp_ill++;
      end
    end
    if (fl) sb.delete();
    else if (v && in_ready) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stepm(input logic [15:0] ins, input logic ordy);
    step(1'b1, ins, model(ins), ordy, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 16'h0000, '0, ordy, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),    32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid),   32'd0);
    chk({tag, "_opcode"},    32'(out_opcode),  32'd0);
    chk({tag, "_rdest"},     32'(out_rdest),   32'd0);
    chk({tag, "_rsrc"},      32'(out_rsrc),    32'd0);
    chk({tag, "_imm"},       32'(out_imm),     32'd0);
    chk({tag, "_is_imm"},    32'(out_is_imm),  32'd0);
    chk({tag, "_illegal"},   32'(out_illegal), 32'd0);
`ifdef DECODE_PERF_CNT_EN
    chk({tag, "_perf_dec"},  perf_decoded,       32'd0);
    chk({tag, "_perf_ill"},  32'(perf_illegal),  32'd0);
`endif
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 16'h0000;
    out_ready = 1'b0;
    #3;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    chk_rdy = 1'b1;

    // Directed decodes with literal expectations
    step(1'b1, 16'h53FF, mk(8'h5F, 4'h3, 4'hF, 16'hFFFF, 1'b1, 1'b0), 1'b1, 1'b0);
    step(1'b1, 16'h1280, mk(8'h18, 4'h2, 4'h0, 16'h0080, 1'b1, 1'b0), 1'b1, 1'b0);
    step(1'b1, 16'hF1AB, mk(8'hFA, 4'h1, 4'hB, 16'hAB00, 1'b1, 1'b0), 1'b1, 1'b0);
    step(1'b1, 16'h0152, mk(8'h05, 4'h1, 4'h2, 16'h0000, 1'b0, 1'b0), 1'b1, 1'b0);
    step(1'b1, 16'h6000, mk(8'h60, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b1), 1'b1, 1'b0);
    step(1'b1, 16'h00F0, mk(8'h0F, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b1), 1'b1, 1'b0);

    // Remaining classes via the reference model
    stepm(16'h8015, 1'b1);
    stepm(16'h8025, 1'b1);
    stepm(16'h4123, 1'b1);
    stepm(16'h9180, 1'b1);
    stepm(16'h3A7F, 1'b1);
    stepm(16'h7000, 1'b1);
    stepm(16'h0000, 1'b1);
    stepm(16'hE456, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: two accepted, third held off, head stable
    stepm(16'h5101, 1'b0);
    stepm(16'h5202, 1'b0);
    stepm(16'h5303, 1'b0);
    stepm(16'h5303, 1'b0);
    stepm(16'h5303, 1'b1);
    stepm(16'h5303, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with both entries full and input presented
    stepm(16'h5111, 1'b0);
    stepm(16'h5222, 1'b0);
    step(1'b1, 16'h5333, model(16'h5333), 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with one entry and an acceptable input; output transfers that edge
    stepm(16'h5444, 1'b0);
    step(1'b1, 16'h5555, model(16'h5555), 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset mid-stream
    stepm(16'h5666, 1'b0);
    stepm(16'h5777, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    sb.delete();
    exp_dec = 0;
    exp_ill = 0;
    chk_rdy = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_async", 32'(in_ready), 32'd1);
    chk_rdy = 1'b1;
    step(1'b1, 16'h53FF, mk(8'h5F, 4'h3, 4'hF, 16'hFFFF, 1'b1, 1'b0), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
